// File: rtl/sram_like_bridge_pkg.sv
// Shared types for the SRAM-like bridge: FSM encoding, latched bus request
// fields and a small sizing helper.
package sram_like_bridge_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic                      wr;
        logic [DATA_W_DEF/8-1:0]   wstrb;
        logic [ADDR_W_DEF-1:0]     addr;
        logic [DATA_W_DEF-1:0]     wdata;
    } bus_req_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_like_bridge_if.sv
// CPU-channel and SRAM-like bus signals of the bridge. The slave modport is
// the bridge itself; master is the surrounding core plus memory.
interface sram_like_bridge_if
    import sram_like_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_CH   = 2
);
    logic [N_CH-1:0]          ch_req;
    logic [N_CH-1:0]          ch_wr;
    logic [N_CH*DATA_W/8-1:0] ch_wstrb;
    logic [N_CH*ADDR_W-1:0]   ch_addr;
    logic [N_CH*DATA_W-1:0]   ch_wdata;
    logic [DATA_W-1:0]        ch_rdata;
    logic [N_CH-1:0]          ch_stall;
    logic [N_CH-1:0]          ch_err;

    logic                     bus_req;
    logic                     bus_wr;
    logic [DATA_W/8-1:0]      bus_wstrb;
    logic [ADDR_W-1:0]        bus_addr;
    logic [DATA_W-1:0]        bus_wdata;
    logic                     bus_addr_ok;
    logic                     bus_data_ok;
    logic [DATA_W-1:0]        bus_rdata;

    modport slave (
        input  ch_req, ch_wr, ch_wstrb, ch_addr, ch_wdata,
        output ch_rdata, ch_stall, ch_err,
        output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport master (
        output ch_req, ch_wr, ch_wstrb, ch_addr, ch_wdata,
        input  ch_rdata, ch_stall, ch_err,
        input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );

endinterface

// File: rtl/sram_like_bridge_fixed_prio_arbiter.sv
// Combinational fixed-priority arbiter: lowest requesting index wins,
// reported both one-hot and as a binary index.
module sram_like_bridge_fixed_prio_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !any) begin
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_like_bridge.sv
// Arbitrates N_CH stalling CPU channels onto one SRAM-like request/addr_ok/
// data_ok bus, one transaction outstanding, with a WAIT-state watchdog.
//
// state | meaning
// IDLE  | arbitrate, latch winner's fields
// REQ   | bus_req high until addr_ok
// WAIT  | address accepted, waiting for data_ok or watchdog
// DONE  | one-cycle completion to the granted channel
module sram_like_bridge
    import sram_like_bridge_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int N_CH    = 2,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    sram_like_bridge_if.slave io
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(N_CH);
    localparam int TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state, state_next;
    bus_req_t          req_q, req_sel;
    logic [N_CH-1:0]   gnt, gnt_q, done;
    logic [IDX_W-1:0]  gnt_idx;
    logic              any_req;
    logic              err_q;
    logic              enter_wait, enter_done, timed_out;
    logic [DATA_W-1:0] rdata_q;
    logic [TMR_W-1:0]  timer;

    sram_like_bridge_fixed_prio_arbiter #(
        .N     (N_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (io.ch_req),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (any_req)
    );

    always_comb begin
        req_sel.wr    = io.ch_wr[gnt_idx];
        req_sel.wstrb = io.ch_wstrb[gnt_idx*STRB_W +: STRB_W];
        req_sel.addr  = io.ch_addr[gnt_idx*ADDR_W +: ADDR_W];
        req_sel.wdata = io.ch_wdata[gnt_idx*DATA_W +: DATA_W];
    end

    always_comb begin
        state_next = state;
        enter_wait = 1'b0;
        enter_done = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (io.bus_addr_ok && io.bus_data_ok) begin
                    state_next = ST_DONE;
                    enter_done = 1'b1;
                end else if (io.bus_addr_ok) begin
                    state_next = ST_WAIT;
                    enter_wait = 1'b1;
                end
            end
            ST_WAIT: begin
                // A data_ok coinciding with the watchdog wins: normal completion.
                if (io.bus_data_ok) begin
                    state_next = ST_DONE;
                    enter_done = 1'b1;
                end else if (TIMEOUT != 0 && timer == TMR_W'(TIMEOUT)) begin
                    state_next = ST_DONE;
                    enter_done = 1'b1;
                    timed_out  = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            gnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            timer   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && any_req) begin
                req_q <= req_sel;
                gnt_q <= gnt;
            end
            if (enter_done) begin
                rdata_q <= timed_out ? '0 : io.bus_rdata;
                err_q   <= timed_out;
            end
            if (enter_wait) begin
                timer <= '0;
            end else if (state == ST_WAIT && timer != {TMR_W{1'b1}}) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

    assign done        = (state == ST_DONE) ? gnt_q : '0;
    assign io.ch_err   = (state == ST_DONE && err_q) ? gnt_q : '0;
    assign io.ch_stall = io.ch_req & ~done;
    assign io.ch_rdata = rdata_q;

    assign io.bus_req   = (state == ST_REQ);
    assign io.bus_wr    = req_q.wr;
    assign io.bus_wstrb = req_q.wstrb;
    assign io.bus_addr  = req_q.addr;
    assign io.bus_wdata = req_q.wdata;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Scoreboard bench for sram_like_bridge: directed accesses push expected
// completions and bus requests; monitors pop and compare.
module tb_sram_like_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NC = 2;
    localparam int SW = DW / 8;

    typedef struct {
        int          ch;
        logic [31:0] rdata;
        bit          wr;
        bit          err;
        int          stall;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          cycles;
    } bus_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_like_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .N_CH(NC)) io ();

    sram_like_bridge #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .N_CH    (NC),
        .TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int n_cmp = 0;
    int n_bad = 0;

    exp_t        sb_q[$];
    bus_exp_t    bus_q[$];
    logic [31:0] resp_q[$];
    int          stall_cnt[NC];
    int          s_addr_dly = 0;
    int          s_data_dly = 0;
    bit          s_hang     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion monitor
    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < NC; i++) begin
                    if (io.ch_stall[i]) stall_cnt[i]++;
                    if (io.ch_req[i] && !io.ch_stall[i]) begin
                        if (sb_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_done: ch%0d completed, none expected", i);
                        end else begin
                            e = sb_q.pop_front();
                            chk("done_ch", i, e.ch);
                            chk("stall_cycles", stall_cnt[i], e.stall);
                            chk("ch_err", {31'd0, io.ch_err[i]}, {31'd0, e.err});
                            if (!e.wr) chk("ch_rdata", io.ch_rdata, e.rdata);
                        end
                        stall_cnt[i] = 0;
                    end else if (io.ch_err[i]) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL err_without_done: ch_err[%0d]=1 got without done", i);
                    end
                end
            end
        end
    end

    // Bus request monitor
    bit       in_txn = 1'b0;
    int       hi_cnt = 0;
    bus_exp_t cur;
    initial begin
        forever begin
            @(negedge clk);
            if (io.bus_req) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    hi_cnt = 0;
                    if (bus_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL bus_reissue: bus_req got 1, expected no request");
                    end else begin
                        cur = bus_q.pop_front();
                    end
                end
                hi_cnt++;
                chk("bus_addr", io.bus_addr, cur.addr);
                chk("bus_wr", {31'd0, io.bus_wr}, {31'd0, cur.wr});
                chk("bus_wstrb", {28'd0, io.bus_wstrb}, {28'd0, cur.wstrb});
                chk("bus_wdata", io.bus_wdata, cur.wdata);
            end else if (in_txn) begin
                in_txn = 1'b0;
                chk("bus_req_cycles", hi_cnt, cur.cycles);
            end
        end
    end

    task automatic give_data();
        io.bus_data_ok = 1'b1;
        io.bus_rdata   = (resp_q.size() != 0) ? resp_q.pop_front() : 32'hBAD0BAD0;
    endtask

    // Slave model, driven away from the rising edge
    initial begin
        io.bus_addr_ok = 1'b0;
        io.bus_data_ok = 1'b0;
        io.bus_rdata   = '0;
        forever begin
            @(negedge clk);
            io.bus_addr_ok = 1'b0;
            io.bus_data_ok = 1'b0;
            if (io.bus_req && !rst) begin
                repeat (s_addr_dly) @(negedge clk);
                io.bus_addr_ok = 1'b1;
                if (!s_hang && s_data_dly == 0) begin
                    give_data();
                end else begin
                    @(negedge clk);
                    io.bus_addr_ok = 1'b0;
                    if (!s_hang) begin
                        repeat (s_data_dly - 1) @(negedge clk);
                        give_data();
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int ch, input bit wr, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input bit err,
                         input int stall, input int bus_cyc);
        sb_q.push_back(exp_t'{ch, exp_rdata, wr, err, stall});
        bus_q.push_back(bus_exp_t'{addr, wr, strb, wdata, bus_cyc});
        io.ch_wr[ch]               = wr;
        io.ch_wstrb[ch*SW +: SW]   = strb;
        io.ch_addr[ch*AW +: AW]    = addr;
        io.ch_wdata[ch*DW +: DW]   = wdata;
        io.ch_req[ch]              = 1'b1;
    endtask

    task automatic run_until_idle(input int budget);
        int          left;
        logic [NC-1:0] drop;
        left = budget;
        while (io.ch_req != '0 && left > 0) begin
            @(negedge clk);
            drop = io.ch_req & ~io.ch_stall;
            @(posedge clk);
            #1;
            io.ch_req = io.ch_req & ~drop;
            left--;
        end
        if (io.ch_req != '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL completion_timeout: ch_req still %b, expected 00", io.ch_req);
            io.ch_req = '0;
        end
    endtask

    task automatic slave_cfg(input int a, input int d, input bit h);
        s_addr_dly = a;
        s_data_dly = d;
        s_hang     = h;
    endtask

    initial begin
        io.ch_req   = '0;
        io.ch_wr    = '0;
        io.ch_wstrb = '0;
        io.ch_addr  = '0;
        io.ch_wdata = '0;

        // Reset values; stall mirrors request while nothing is done
        io.ch_req = 2'b10;
        #12;
        chk("rst_bus_req", {31'd0, io.bus_req}, 32'd0);
        chk("rst_bus_wr", {31'd0, io.bus_wr}, 32'd0);
        chk("rst_bus_wstrb", {28'd0, io.bus_wstrb}, 32'd0);
        chk("rst_bus_addr", io.bus_addr, 32'd0);
        chk("rst_bus_wdata", io.bus_wdata, 32'd0);
        chk("rst_ch_rdata", io.ch_rdata, 32'd0);
        chk("rst_ch_err", {30'd0, io.ch_err}, 32'd0);
        chk("rst_ch_stall", {30'd0, io.ch_stall}, 32'd2);
        io.ch_req = '0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Zero-wait read on channel 0
        slave_cfg(0, 0, 1'b0);
        resp_q.push_back(32'h3C1D0001);
        issue(0, 1'b0, 4'h0, 32'hBFC00000, 32'h0, 32'h3C1D0001, 1'b0, 2, 1);
        run_until_idle(30);
        tick();

        // Contention: channel 0 first, channel 1 stalls throughout
        resp_q.push_back(32'h11111111);
        resp_q.push_back(32'h22222222);
        issue(0, 1'b0, 4'h0, 32'h00001000, 32'h0, 32'h11111111, 1'b0, 2, 1);
        issue(1, 1'b0, 4'h0, 32'h00002000, 32'h0, 32'h22222222, 1'b0, 5, 1);
        run_until_idle(30);
        tick();

        // Delayed slave: addr_ok 2 late, data_ok 3 after that
        slave_cfg(2, 3, 1'b0);
        resp_q.push_back(32'hA5A55A5A);
        issue(1, 1'b0, 4'h0, 32'h00003000, 32'h0, 32'hA5A55A5A, 1'b0, 7, 3);
        run_until_idle(30);
        tick();

        // Zero-wait write on channel 0
        slave_cfg(0, 0, 1'b0);
        issue(0, 1'b1, 4'b0011, 32'h00004000, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        run_until_idle(30);
        tick();

        // Write on channel 1 with one WAIT cycle
        slave_cfg(0, 1, 1'b0);
        issue(1, 1'b1, 4'b1100, 32'h00004400, 32'hCAFEF00D, 32'h0, 1'b0, 3, 1);
        run_until_idle(30);
        tick();

        // Watchdog: WAIT entered at cycle 2, done with err at cycle 7
        slave_cfg(0, 0, 1'b1);
        issue(0, 1'b0, 4'h0, 32'h00005000, 32'h0, 32'h0, 1'b0 | 1'b1, 7, 1);
        run_until_idle(30);
        tick();

        // data_ok in the same cycle as the watchdog: normal completion
        slave_cfg(0, 5, 1'b0);
        resp_q.push_back(32'h0BADF00D);
        issue(1, 1'b0, 4'h0, 32'h00006000, 32'h0, 32'h0BADF00D, 1'b0, 7, 1);
        run_until_idle(30);
        tick();

        // Asynchronous reset in the middle of WAIT
        slave_cfg(0, 0, 1'b1);
        issue(0, 1'b0, 4'h0, 32'h00007000, 32'h0, 32'h0, 1'b0, 99, 1);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_bus_req", {31'd0, io.bus_req}, 32'd0);
        chk("midrst_ch_stall", {30'd0, io.ch_stall}, 32'd1);
        chk("midrst_ch_err", {30'd0, io.ch_err}, 32'd0);
        chk("midrst_ch_rdata", io.ch_rdata, 32'd0);
        chk("midrst_bus_addr", io.bus_addr, 32'd0);
        io.ch_req = '0;
        sb_q.delete();
        for (int i = 0; i < NC; i++) stall_cnt[i] = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        slave_cfg(0, 0, 1'b0);
        tick();

        // Normal access after reset
        resp_q.push_back(32'h12345678);
        issue(1, 1'b0, 4'h0, 32'h00008000, 32'h0, 32'h12345678, 1'b0, 2, 1);
        run_until_idle(30);
        repeat (3) tick();

        chk("sb_drained", sb_q.size(), 32'd0);
        chk("bus_q_drained", bus_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
